// File: rtl/atmega_pio_rmw_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// atmega_pio_rmw_pkg - op codes, FSM encoding and defaults for the RMW arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package atmega_pio_rmw_pkg;

   localparam logic [2:0] OP_READ  = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_SET   = 3'd2;
   localparam logic [2:0] OP_CLR   = 3'd3;
   localparam logic [2:0] OP_TEST  = 3'd4;
   localparam logic [2:0] OP_TGL   = 3'd5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RD    = 2'd1;
   localparam logic [1:0] ST_WR    = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int unsigned DEFAULT_BITOP_MAX_ADDR = 32'h1F;

   function automatic logic [7:0] bit_mask(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/atmega_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// atmega_rr_arb2 - two-way round-robin grant with a last-grant pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module atmega_rr_arb2 #(
   parameter bit RR_RESET_LAST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
         else                  gnt = req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last <= RR_RESET_LAST;
      else if (|gnt) last <= gnt[1];
   end

endmodule
`default_nettype wire

// File: rtl/atmega_pio_rmw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// atmega_pio_rmw_arbiter - shares one PIO I/O port between CPU and debug/DMA,
// sequencing single accesses and RMW bit ops. Option: ATMEGA_PIO_RMW_TOGGLE_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module atmega_pio_rmw_arbiter
   import atmega_pio_rmw_pkg::*;
#(
   parameter int          BUS_ADDR_DATA_LEN = 16,
   parameter int unsigned BITOP_MAX_ADDR    = DEFAULT_BITOP_MAX_ADDR,
   parameter bit          RR_RESET_LAST     = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req0_valid,
   input  logic [2:0]                   req0_op,
   input  logic [5:0]                   req0_addr,
   input  logic [2:0]                   req0_bit,
   input  logic [7:0]                   req0_wdata,
   output logic                         req0_ready,
   output logic                         rsp0_valid,
   output logic [7:0]                   rsp0_rdata,
   output logic                         rsp0_flag,
   output logic                         rsp0_err,
   input  logic                         req1_valid,
   input  logic [2:0]                   req1_op,
   input  logic [5:0]                   req1_addr,
   input  logic [2:0]                   req1_bit,
   input  logic [7:0]                   req1_wdata,
   output logic                         req1_ready,
   output logic                         rsp1_valid,
   output logic [7:0]                   rsp1_rdata,
   output logic                         rsp1_flag,
   output logic                         rsp1_err,
   output logic [BUS_ADDR_DATA_LEN-1:0] io_addr,
   output logic                         io_rd,
   output logic                         io_wr,
   output logic [7:0]                   io_dout,
   input  logic [7:0]                   io_din
);

   logic [1:0] state, state_nxt;
   logic [1:0] gnt;
   logic       sel, accept;
   logic [2:0] sel_op, sel_bit;
   logic [5:0] sel_addr;
   logic [7:0] sel_wdata;
   logic [2:0] op_q, bit_q;
   logic [5:0] addr_q;
   logic [7:0] wdata_q, data_q, wr_value;
   logic       id_q;
   logic       rsp_go, rsp_id, rsp_flag, rsp_err;
   logic [7:0] rsp_data;

   function automatic logic op_legal(input logic [2:0] op, input logic [5:0] addr);
      logic in_range;
      in_range = (32'(addr) <= BITOP_MAX_ADDR);
      case (op)
         OP_READ, OP_WRITE:       op_legal = 1'b1;
         OP_SET, OP_CLR, OP_TEST: op_legal = in_range;
`ifdef ATMEGA_PIO_RMW_TOGGLE_EN
         OP_TGL:                  op_legal = in_range;
`endif
         default:                 op_legal = 1'b0;
      endcase
   endfunction

   atmega_rr_arb2 #(.RR_RESET_LAST(RR_RESET_LAST)) u_arb (
      .clk (clk),
      .rst (rst),
      .en  (state == ST_IDLE && !rst),
      .req ({req1_valid, req0_valid}),
      .gnt (gnt)
   );

   assign sel       = gnt[1];
   assign accept    = |gnt;
   assign sel_op    = sel ? req1_op    : req0_op;
   assign sel_addr  = sel ? req1_addr  : req0_addr;
   assign sel_bit   = sel ? req1_bit   : req0_bit;
   assign sel_wdata = sel ? req1_wdata : req0_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!op_legal(sel_op, sel_addr)) state_nxt = ST_RESP;
               else if (sel_op == OP_WRITE)     state_nxt = ST_WR;
               else                             state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = (op_q == OP_READ || op_q == OP_TEST) ? ST_RESP : ST_WR;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      io_rd      = 1'b0;
      io_wr      = 1'b0;
      io_dout    = 8'h00;
      case (state)
         ST_IDLE: begin
            req0_ready = gnt[0];
            req1_ready = gnt[1];
         end
         ST_RD:   io_rd = 1'b1;
         ST_WR: begin
            io_wr   = 1'b1;
            io_dout = wr_value;
         end
         default: ;
      endcase
   end

   assign io_addr = {{(BUS_ADDR_DATA_LEN-6){1'b0}}, addr_q};

   always_comb begin
      case (op_q)
         OP_SET:  wr_value = data_q | bit_mask(bit_q);
         OP_CLR:  wr_value = data_q & ~bit_mask(bit_q);
`ifdef ATMEGA_PIO_RMW_TOGGLE_EN
         OP_TGL:  wr_value = data_q ^ bit_mask(bit_q);
`endif
         default: wr_value = wdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= OP_READ;
         addr_q  <= 6'd0;
         bit_q   <= 3'd0;
         wdata_q <= 8'h00;
         id_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         if (state == ST_IDLE && accept) begin
            op_q    <= sel_op;
            addr_q  <= sel_addr;
            bit_q   <= sel_bit;
            wdata_q <= sel_wdata;
            id_q    <= sel;
         end
         if (state == ST_RD) data_q <= io_din;
      end
   end

   // Response contents are resolved one cycle early so the rsp outputs are flops.
   always_comb begin
      rsp_go   = (state_nxt == ST_RESP);
      rsp_id   = (state == ST_IDLE) ? sel : id_q;
      rsp_data = 8'h00;
      rsp_flag = 1'b0;
      rsp_err  = 1'b0;
      case (state)
         ST_IDLE: rsp_err  = 1'b1;
         ST_RD: begin
            rsp_data = io_din;
            rsp_flag = (op_q == OP_TEST) && io_din[bit_q];
         end
         ST_WR:   rsp_data = (op_q == OP_WRITE) ? 8'h00 : data_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0; rsp0_rdata <= 8'h00; rsp0_flag <= 1'b0; rsp0_err <= 1'b0;
         rsp1_valid <= 1'b0; rsp1_rdata <= 8'h00; rsp1_flag <= 1'b0; rsp1_err <= 1'b0;
      end else begin
         rsp0_valid <= rsp_go && !rsp_id;
         rsp0_rdata <= (rsp_go && !rsp_id) ? rsp_data : 8'h00;
         rsp0_flag  <= rsp_go && !rsp_id && rsp_flag;
         rsp0_err   <= rsp_go && !rsp_id && rsp_err;
         rsp1_valid <= rsp_go && rsp_id;
         rsp1_rdata <= (rsp_go && rsp_id) ? rsp_data : 8'h00;
         rsp1_flag  <= rsp_go && rsp_id && rsp_flag;
         rsp1_err   <= rsp_go && rsp_id && rsp_err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_atmega_pio_rmw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_atmega_pio_rmw_arbiter - transaction-level model check of the RMW arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_atmega_pio_rmw_arbiter;

   localparam logic [5:0] BITOP_MAX = 6'h1F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
   logic [5:0]  req0_addr = 6'd0, req1_addr = 6'd0;
   logic [2:0]  req0_bit = 3'd0, req1_bit = 3'd0;
   logic [7:0]  req0_wdata = 8'h00, req1_wdata = 8'h00;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid, rsp0_flag, rsp1_flag, rsp0_err, rsp1_err;
   logic [7:0]  rsp0_rdata, rsp1_rdata;
   logic [15:0] io_addr;
   logic        io_rd, io_wr;
   logic [7:0]  io_dout, io_din;

   logic [7:0]  pio [64];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_addr = 6'd0;
   logic [7:0]  poke_val = 8'h00;

   int compared = 0, mismatched = 0;

   // model state shared with the stimulus for literal checks
   logic [7:0]  ref_mem [64];
   int          grants[$];
   logic [7:0]  last_rdata [2];
   logic        last_flag [2], last_err [2];
   int          last_lat [2];
   int          rd_cnt = 0, wr_cnt = 0;
   logic [7:0]  last_wdout = 8'h00;

   always #5 clk = ~clk;

   atmega_pio_rmw_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr),
      .req0_bit(req0_bit), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_flag(rsp0_flag), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr),
      .req1_bit(req1_bit), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_flag(rsp1_flag), .rsp1_err(rsp1_err),
      .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_dout(io_dout), .io_din(io_din)
   );

   // PIO register file on the far side of the bus
   assign io_din = pio[io_addr[5:0]];
   always @(posedge clk) begin
      if (io_wr)        pio[io_addr[5:0]] <= io_dout;
      else if (poke_en) pio[poke_addr]    <= poke_val;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Transaction-level model: on each accept the whole bus/response schedule is derived
   initial begin : model
      logic [49:0] av, ev, mk;
      logic        busy, last_gnt, w, bitop, legal, have;
      logic        s_rd [4], s_wr [4];
      logic [7:0]  s_dout [4];
      logic        p_id, p_err, p_flag, p_upd;
      logic [7:0]  p_rdata, p_new, cur, m, wd;
      logic [5:0]  p_addr, a;
      logic [2:0]  op, b;
      logic        er0, er1, ev0, ev1, ef0, ef1, ee0, ee1, erd, ewr, ac, dc;
      logic [7:0]  ed0, ed1, edout;
      logic [15:0] eaddr;
      int          k, lat_n, cyc, acc_cyc;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 4; i++) begin s_rd[i] = 0; s_wr[i] = 0; s_dout[i] = 0; end
      busy = 0; last_gnt = 1; k = 0; lat_n = 0; cyc = 0; acc_cyc = 0;
      p_id = 0; p_err = 0; p_flag = 0; p_upd = 0; p_rdata = 0; p_new = 0; p_addr = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (io_rd) rd_cnt++;
         if (io_wr) begin wr_cnt++; last_wdout = io_dout; end
         if (rsp0_valid) begin
            last_rdata[0] = rsp0_rdata; last_flag[0] = rsp0_flag;
            last_err[0] = rsp0_err; last_lat[0] = cyc - acc_cyc;
         end
         if (rsp1_valid) begin
            last_rdata[1] = rsp1_rdata; last_flag[1] = rsp1_flag;
            last_err[1] = rsp1_err; last_lat[1] = cyc - acc_cyc;
         end
         if (poke_en) ref_mem[poke_addr] = poke_val;
         er0 = 0; er1 = 0; ev0 = 0; ev1 = 0; ef0 = 0; ef1 = 0; ee0 = 0; ee1 = 0;
         erd = 0; ewr = 0; ed0 = 0; ed1 = 0; edout = 0; eaddr = 0; ac = 0; dc = 0;
         if (rst) begin
            busy = 0; last_gnt = 1; ac = 1; dc = 1;
         end else if (busy) begin
            k++;
            erd = s_rd[k]; ewr = s_wr[k]; edout = s_dout[k];
            eaddr = {10'd0, p_addr}; ac = erd | ewr; dc = ewr;
            if (k == lat_n) begin
               busy = 0;
               if (p_id) begin ev1 = 1; ed1 = p_rdata; ef1 = p_flag; ee1 = p_err; end
               else      begin ev0 = 1; ed0 = p_rdata; ef0 = p_flag; ee0 = p_err; end
               if (p_upd) ref_mem[p_addr] = p_new;
            end
         end else begin
            have = req0_valid | req1_valid;
            w = (req0_valid && req1_valid) ? !last_gnt : req1_valid;
            if (have) begin
               op = w ? req1_op : req0_op;     a  = w ? req1_addr : req0_addr;
               b  = w ? req1_bit : req0_bit;   wd = w ? req1_wdata : req0_wdata;
               cur = ref_mem[a]; m = 8'h01 << b;
               for (int i = 0; i < 4; i++) begin s_rd[i] = 0; s_wr[i] = 0; s_dout[i] = 0; end
               p_id = w; p_addr = a; p_err = 0; p_flag = 0; p_rdata = 0; p_upd = 0; p_new = 0;
               bitop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
`ifdef ATMEGA_PIO_RMW_TOGGLE_EN
               bitop = bitop || (op == 3'd5);
`endif
               legal = (op == 3'd0) || (op == 3'd1) || (bitop && a <= BITOP_MAX);
               if (!legal) begin
                  lat_n = 1; p_err = 1;
               end else if (op == 3'd1) begin
                  lat_n = 2; s_wr[1] = 1; s_dout[1] = wd; p_upd = 1; p_new = wd;
               end else if (op == 3'd0 || op == 3'd4) begin
                  lat_n = 2; s_rd[1] = 1; p_rdata = cur; p_flag = (op == 3'd4) && cur[b];
               end else begin
                  lat_n = 3; s_rd[1] = 1; s_wr[2] = 1; p_rdata = cur; p_upd = 1;
                  p_new = (op == 3'd2) ? (cur | m) : (op == 3'd3) ? (cur & ~m) : (cur ^ m);
                  s_dout[2] = p_new;
               end
               busy = 1; k = 0; acc_cyc = cyc; last_gnt = w;
               grants.push_back(int'(w));
               er0 = !w; er1 = w;
            end
         end
         av = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
               rsp0_flag, rsp1_flag, rsp0_err, rsp1_err, io_rd, io_wr, io_addr, io_dout};
         ev = {er0, er1, ev0, ev1, ed0, ed1, ef0, ef1, ee0, ee1, erd, ewr, eaddr, edout};
         mk = {{26{1'b1}}, {16{ac}}, {8{dc}}};
         check($sformatf("cycle %0d outputs", cyc), 64'(av & mk), 64'(ev & mk));
      end
   end

   task automatic poke(input logic [5:0] a, input logic [7:0] v);
      poke_addr = a; poke_val = v; poke_en = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic n, input logic [2:0] op, input logic [5:0] a,
                         input logic [2:0] b, input logic [7:0] wd);
      logic got;
      if (!n) begin req0_op = op; req0_addr = a; req0_bit = b; req0_wdata = wd; req0_valid = 1'b1; end
      else    begin req1_op = op; req1_addr = a; req1_bit = b; req1_wdata = wd; req1_valid = 1'b1; end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         got = n ? req1_ready : req0_ready;
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (!got) begin timeout("ready"); return; end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         got = n ? rsp1_valid : rsp0_valid;
         if (!got) begin @(negedge clk); #1; end
      end
      if (!got) begin timeout("rsp_valid"); return; end
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r0, w0;
      logic got;
      poke(6'h10, 8'hA5);
      poke(6'h11, 8'h5A);
      poke(6'h05, 8'h10);
      poke(6'h03, 8'h80);
      poke(6'h06, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // both requesters reading continuously from reset
      grants.delete();
      req0_op = 3'd0; req0_addr = 6'h10; req1_op = 3'd0; req1_addr = 6'h11;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 60 && grants.size() < 4; i++) @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (grants.size() < 4) timeout("rr_grants");
      else begin
         check("rr_grant0", 64'(grants[0]), 64'd0);
         check("rr_grant1", 64'(grants[1]), 64'd1);
         check("rr_grant2", 64'(grants[2]), 64'd0);
         check("rr_grant3", 64'(grants[3]), 64'd1);
      end
      wait_cycles(5);
      check("rr_rdata0", 64'(last_rdata[0]), 64'hA5);
      check("rr_rdata1", 64'(last_rdata[1]), 64'h5A);

      // SET addr 5 bit 3 on 0x10
      do_req(1'b0, 3'd2, 6'h05, 3'd3, 8'h00);
      check("set_rdata", 64'(last_rdata[0]), 64'h10);
      check("set_err", 64'(last_err[0]), 64'd0);
      check("set_lat", 64'(last_lat[0]), 64'd3);
      check("set_dout", 64'(last_wdout), 64'h18);
      check("set_reg", 64'(pio[5]), 64'h18);

      // TEST addr 3 bit 7 on 0x80
      w0 = wr_cnt;
      do_req(1'b1, 3'd4, 6'h03, 3'd7, 8'h00);
      check("test_flag", 64'(last_flag[1]), 64'd1);
      check("test_rdata", 64'(last_rdata[1]), 64'h80);
      check("test_lat", 64'(last_lat[1]), 64'd2);
      check("test_no_wr", 64'(wr_cnt - w0), 64'd0);

      // CLR above the bit-op range
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b0, 3'd3, 6'h25, 3'd2, 8'h00);
      check("clr_err", 64'(last_err[0]), 64'd1);
      check("clr_lat", 64'(last_lat[0]), 64'd1);
      check("clr_no_bus", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);

      // op 5 on addr 5 bit 0 with 0x01
      poke(6'h05, 8'h01);
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b0, 3'd5, 6'h05, 3'd0, 8'h00);
`ifdef ATMEGA_PIO_RMW_TOGGLE_EN
      check("tgl_err", 64'(last_err[0]), 64'd0);
      check("tgl_dout", 64'(last_wdout), 64'h00);
      check("tgl_lat", 64'(last_lat[0]), 64'd3);
      check("tgl_reg", 64'(pio[5]), 64'h00);
`else
      check("tgl_err", 64'(last_err[0]), 64'd1);
      check("tgl_lat", 64'(last_lat[0]), 64'd1);
      check("tgl_no_bus", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
      check("tgl_reg", 64'(pio[5]), 64'h01);
`endif

      // plain WRITE from req1
      do_req(1'b1, 3'd1, 6'h3A, 3'd0, 8'h5C);
      check("wr_reg", 64'(pio[6'h3A]), 64'h5C);
      check("wr_lat", 64'(last_lat[1]), 64'd2);
      check("wr_err", 64'(last_err[1]), 64'd0);

      // reset during the WR cycle of a SET
      req0_op = 3'd2; req0_addr = 6'h06; req0_bit = 3'd1; req0_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         got = req0_ready;
      end
      if (!got) timeout("rst_set_ready");
      @(posedge clk);
      @(posedge clk); #1;
      check("wr_before_rst", 64'(io_wr), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_wr_drop", 64'(io_wr), 64'd0);
      check("rst_rd_drop", 64'(io_rd), 64'd0);
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_cycles(2);
      check("rst_reg_kept", 64'(pio[6]), 64'h00);

      grants.delete();
      req0_op = 3'd0; req0_addr = 6'h10; req1_op = 3'd0; req1_addr = 6'h11;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 20 && grants.size() == 0; i++) @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (grants.size() == 0) timeout("post_rst_grant");
      else check("post_rst_grant", 64'(grants[0]), 64'd0);
      wait_cycles(5);
      check("post_rst_rdata", 64'(last_rdata[0]), 64'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
